sipo_piso_master: RTL

Serial register-bus master that sequences frames for the slave-side serial-in/parallel-out register file (5-bit address, 8-bit register, 13-bit frame). It accepts parallel read/write requests from two on-chip requesters (host config port 0, calibration FSM port 1) and round-robin arbitrates between them. For each request it generates the `strobe`/`wr_en`/`din` frame and captures `dout` on reads. It sits between the digital control logic and the analog-side config register bank.

---
 rtl/sipo_piso_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sipo_piso_master.sv
//==============================================================================
// sipo_piso_master : round-robin master issuing 13-bit strobe/wr_en/din frames.
// Optional macro SPM_VERIFY_EN adds an automatic read-back after each write. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sipo_piso_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [REG_WIDTH-1:0]  wdata0,
  input  logic [REG_WIDTH-1:0]  wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  verify_err,
  output logic                  busy,
  output logic                  strobe,
  output logic                  wr_en,
  output logic                  din,
  input  logic                  dout
);

  localparam int FRAME   = ADDR_WIDTH + REG_WIDTH;
  localparam int CNT_MAX = (FRAME > GAP_CYCLES) ? FRAME : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] c_last_slot = CW'(FRAME - 1);
  localparam logic [CW-1:0] c_last_gap  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] c_first_rd  = CW'(ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [FRAME-1:0]      r_sreg, w_sreg;
  logic [REG_WIDTH-1:0]  r_rxd, w_rxd;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [REG_WIDTH-1:0]  r_wdata, w_wdata;
  logic                  r_gid, w_gid;
  logic                  r_prio1, w_prio1;
  logic                  r_vchk, w_vchk;
  logic                  r_strobe, w_strobe;
  logic                  r_wr_en, w_wr_en;
  logic                  r_din, w_din;
  logic                  r_ack0, w_ack0;
  logic                  r_ack1, w_ack1;
  logic [REG_WIDTH-1:0]  r_rdata, w_rdata;
  logic                  r_verr, w_verr;
  logic                  r_busy;
  logic                  w_grant1;
  logic [REG_WIDTH-1:0]  w_rd_word;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sreg    = r_sreg;
    w_rxd     = r_rxd;
    w_we      = r_we;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_gid     = r_gid;
    w_prio1   = r_prio1;
    w_vchk    = r_vchk;
    w_strobe  = 1'b0;
    w_wr_en   = r_wr_en;
    w_din     = 1'b0;
    w_ack0    = 1'b0;
    w_ack1    = 1'b0;
    w_rdata   = r_rdata;
    w_verr    = 1'b0;
    w_grant1  = req1 & (~req0 | r_prio1);
    w_rd_word = {dout, r_rxd[REG_WIDTH-1:1]};

    // Every output is registered, so each branch sets the values for the next state.
    case (r_state)
      S_IDLE: begin
        w_wr_en = 1'b0;
        if (r_vchk) begin
          w_we    = 1'b0;
          w_state = S_SETUP;
        end else if (req0 | req1) begin
          w_gid   = w_grant1;
          w_prio1 = ~w_grant1;
          w_we    = w_grant1 ? we1 : we0;
          w_addr  = w_grant1 ? addr1 : addr0;
          w_wdata = w_grant1 ? wdata1 : wdata0;
          w_wr_en = w_we;
          w_state = S_SETUP;
        end
      end
      S_SETUP: begin
        w_sreg   = r_we ? {r_addr, r_wdata} : {{REG_WIDTH{1'b0}}, r_addr};
        w_strobe = 1'b1;
        w_state  = S_STROBE;
      end
      S_STROBE: begin
        w_din   = r_sreg[0];
        w_sreg  = {1'b0, r_sreg[FRAME-1:1]};
        w_cnt   = '0;
        w_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt >= c_first_rd) w_rxd = w_rd_word;
        if (r_cnt == c_last_slot) begin
          w_state = S_DONE;
          w_wr_en = 1'b0;
`ifdef SPM_VERIFY_EN
          if (r_we) begin
            w_vchk = 1'b1;
          end else begin
            w_rdata = w_rd_word;
            w_ack0  = ~r_gid;
            w_ack1  = r_gid;
            w_verr  = r_vchk & (w_rd_word != r_wdata);
            w_vchk  = 1'b0;
          end
`else
          if (!r_we) w_rdata = w_rd_word;
          w_ack0 = ~r_gid;
          w_ack1 = r_gid;
`endif
        end else begin
          w_din  = r_sreg[0];
          w_sreg = {1'b0, r_sreg[FRAME-1:1]};
          w_cnt  = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_wr_en = 1'b0;
        w_cnt   = '0;
        w_state = S_GAP;
      end
      S_GAP: begin
        w_wr_en = 1'b0;
        if (r_cnt == c_last_gap) w_state = S_IDLE;
        else                     w_cnt   = r_cnt + 1'b1;
      end
      default: begin
        w_wr_en = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sreg   <= '0;
      r_rxd    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_gid    <= 1'b0;
      r_prio1  <= 1'b0;
      r_vchk   <= 1'b0;
      r_strobe <= 1'b0;
      r_wr_en  <= 1'b0;
      r_din    <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata  <= '0;
      r_verr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_sreg   <= w_sreg;
      r_rxd    <= w_rxd;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_gid    <= w_gid;
      r_prio1  <= w_prio1;
      r_vchk   <= w_vchk;
      r_strobe <= w_strobe;
      r_wr_en  <= w_wr_en;
      r_din    <= w_din;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_rdata  <= w_rdata;
      r_verr   <= w_verr;
      r_busy   <= (w_state != S_IDLE);
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign rdata      = r_rdata;
  assign verify_err = r_verr;
  assign busy       = r_busy;
  assign strobe     = r_strobe;
  assign wr_en      = r_wr_en;
  assign din        = r_din;

endmodule

`default_nettype wire
